// File: rtl/rtc_pkg.sv
// Shared types and limits for the real-time clock timekeeper.
// Field width, BCD limits, load FSM states and time bundle.
package rtc_pkg;

    localparam int FIELD_W = 8;

    localparam logic [FIELD_W-1:0] SS_MAX = 8'h59;
    localparam logic [FIELD_W-1:0] MM_MAX = 8'h59;
    localparam logic [FIELD_W-1:0] HH_MAX = 8'h23;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } load_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] hh;
        logic [FIELD_W-1:0] mm;
        logic [FIELD_W-1:0] ss;
    } rtc_time_t;

    // Both nibbles must be decimal digits before the packed compare means anything.
    function automatic logic bcd_in_range(
        input logic [FIELD_W-1:0] v,
        input logic [FIELD_W-1:0] max
    );
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed BCD modulo counter with synchronous load.
// carry flags an increment that wraps MAX back to zero.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter logic [FIELD_W-1:0] MAX = SS_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_val,
    output logic [FIELD_W-1:0] q,
    output logic [FIELD_W-1:0] nxt,
    output logic               carry
);

    logic               wrap;
    logic [FIELD_W-1:0] bumped;

    always_comb begin
        wrap   = (q == MAX);
        bumped = q;
        if (q[3:0] == 4'd9) begin
            bumped = {q[7:4] + 4'd1, 4'd0};
        end else begin
            bumped = {q[7:4], q[3:0] + 4'd1};
        end
    end

    // Load outranks increment; a loaded value never produces a carry.
    always_comb begin
        nxt   = q;
        carry = 1'b0;
        if (load) begin
            nxt = load_val;
        end else if (inc) begin
            nxt   = wrap ? '0 : bumped;
            carry = wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// 24-hour BCD timekeeper with validated time load and minute alarm.
// Load commit takes priority over the 1 Hz tick in the same cycle.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int ALARM_ENABLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_done,
    output logic       set_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       alarm
);

    load_state_t state;
    load_state_t state_nxt;
    rtc_time_t   stage;
    logic        stage_ok;
    logic        commit;
    logic        adv;

    logic [FIELD_W-1:0] ss_nxt;
    logic [FIELD_W-1:0] mm_nxt;
    logic [FIELD_W-1:0] hh_nxt;
    logic               ss_carry;
    logic               mm_carry;
    logic               hh_carry;

    logic min_q;
    logic hour_q;
    logic day_q;

    assign stage_ok = bcd_in_range(stage.hh, HH_MAX)
                   && bcd_in_range(stage.mm, MM_MAX)
                   && bcd_in_range(stage.ss, SS_MAX);

    // Result pulses are gated by rst_n so a reset in CHECK aborts silently.
    always_comb begin
        state_nxt = state;
        set_ready = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                set_ready = rst_n;
                if (set_valid && rst_n) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                commit    = rst_n && stage_ok;
                set_done  = commit;
                set_err   = rst_n && !stage_ok;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            stage <= '0;
        end else begin
            state <= state_nxt;
            if (set_valid && set_ready) begin
                stage <= '{hh: set_hh, mm: set_mm, ss: set_ss};
            end
        end
    end

    assign adv = tick && !commit;

    bcd_mod_counter #(.MAX(SS_MAX)) u_ss (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (adv),
        .load     (commit),
        .load_val (stage.ss),
        .q        (ss),
        .nxt      (ss_nxt),
        .carry    (ss_carry)
    );

    bcd_mod_counter #(.MAX(MM_MAX)) u_mm (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (ss_carry),
        .load     (commit),
        .load_val (stage.mm),
        .q        (mm),
        .nxt      (mm_nxt),
        .carry    (mm_carry)
    );

    bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (mm_carry),
        .load     (commit),
        .load_val (stage.hh),
        .q        (hh),
        .nxt      (hh_nxt),
        .carry    (hh_carry)
    );

    // Strobes line up with the cycle the new time becomes visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_q  <= 1'b0;
            hour_q <= 1'b0;
            day_q  <= 1'b0;
        end else begin
            min_q  <= ss_carry;
            hour_q <= mm_carry;
            day_q  <= hh_carry;
        end
    end

    assign min_pulse  = min_q;
    assign hour_pulse = hour_q;
    assign day_pulse  = day_q;

    generate
        if (ALARM_ENABLE != 0) begin : g_alarm
            logic alarm_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    alarm_q <= 1'b0;
                end else begin
                    alarm_q <= alarm_en && adv
                            && ({hh_nxt, mm_nxt, ss_nxt}
                                == {alarm_hh, alarm_mm, 8'h00});
                end
            end
            assign alarm = alarm_q;
        end else begin : g_no_alarm
            assign alarm = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: directed table plus
// randomized traffic against a seconds-of-day reference model.
module tb_rtc_timekeeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       set_valid;
    logic       set_ready;
    logic [7:0] set_hh, set_mm, set_ss;
    logic       set_done, set_err;
    logic [7:0] hh, mm, ss;
    logic       min_pulse, hour_pulse, day_pulse;
    logic       alarm_en;
    logic [7:0] alarm_hh, alarm_mm;
    logic       alarm;

    always #5 clk = ~clk;

    rtc_timekeeper #(.ALARM_ENABLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .set_valid  (set_valid),
        .set_ready  (set_ready),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .set_done   (set_done),
        .set_err    (set_err),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .min_pulse  (min_pulse),
        .hour_pulse (hour_pulse),
        .day_pulse  (day_pulse),
        .alarm_en   (alarm_en),
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .alarm      (alarm)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int i);
        return {4'(i / 10), 4'(i % 10)};
    endfunction

    function automatic bit dec_ok(input logic [7:0] b, input int lim);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b2i(b) <= lim);
    endfunction

    // Reference model: time as seconds of day, load as a pending record.
    bit         m_idle = 1'b1;
    logic [7:0] m_sh = '0, m_sm = '0, m_ss = '0;
    int         m_secs = 0;
    bit         m_min = 0, m_hour = 0, m_day = 0, m_alarm = 0;

    function automatic bit m_stage_ok();
        return dec_ok(m_sh, 23) && dec_ok(m_sm, 59) && dec_ok(m_ss, 59);
    endfunction

    task automatic model_edge();
        bit commit;
        commit = !m_idle && m_stage_ok();
        m_min = 0; m_hour = 0; m_day = 0; m_alarm = 0;
        if (!rst_n) begin
            m_secs = 0;
            m_idle = 1;
            m_sh = '0; m_sm = '0; m_ss = '0;
            return;
        end
        if (commit) begin
            m_secs = b2i(m_sh) * 3600 + b2i(m_sm) * 60 + b2i(m_ss);
        end else if (tick) begin
            m_secs  = (m_secs + 1) % 86400;
            m_min   = (m_secs % 60) == 0;
            m_hour  = (m_secs % 3600) == 0;
            m_day   = m_secs == 0;
            m_alarm = alarm_en
                   && m_secs == b2i(alarm_hh) * 3600 + b2i(alarm_mm) * 60;
        end
        if (m_idle && set_valid) begin
            m_sh = set_hh; m_sm = set_mm; m_ss = set_ss;
            m_idle = 0;
        end else if (!m_idle) begin
            m_idle = 1;
        end
    endtask

    task automatic cycle(input bit use_model,
                         output logic o_rdy, output logic o_done,
                         output logic o_err);
        bit ok;
        #1;
        o_rdy  = set_ready;
        o_done = set_done;
        o_err  = set_err;
        ok = m_stage_ok();
        if (use_model) begin
            chk("set_ready", int'(set_ready), int'(rst_n && m_idle));
            chk("set_done", int'(set_done), int'(rst_n && !m_idle && ok));
            chk("set_err", int'(set_err), int'(rst_n && !m_idle && !ok));
        end
        @(posedge clk);
        model_edge();
        #1;
        if (use_model) begin
            chk("hh", int'(hh), int'(i2b(m_secs / 3600)));
            chk("mm", int'(mm), int'(i2b((m_secs / 60) % 60)));
            chk("ss", int'(ss), int'(i2b(m_secs % 60)));
            chk("min_pulse", int'(min_pulse), int'(m_min));
            chk("hour_pulse", int'(hour_pulse), int'(m_hour));
            chk("day_pulse", int'(day_pulse), int'(m_day));
            chk("alarm", int'(alarm), int'(m_alarm));
        end
    endtask

    typedef struct {
        bit         rst, tk, sv;
        logic [7:0] sh, sm, ss;
        bit         ae;
        logic [7:0] ah, am;
        bit         rdy, dn, er;
        logic [7:0] eh, em, es;
        bit         mi, ho, dy, al;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input bit rst, tk, sv, input logic [7:0] sh, sm, ss_,
        input bit ae, input logic [7:0] ah, am,
        input bit rdy, dn, er, input logic [7:0] eh, em, es,
        input bit mi, ho, dy, al);
        vec_t v;
        v.rst = rst; v.tk = tk; v.sv = sv;
        v.sh = sh; v.sm = sm; v.ss = ss_;
        v.ae = ae; v.ah = ah; v.am = am;
        v.rdy = rdy; v.dn = dn; v.er = er;
        v.eh = eh; v.em = em; v.es = es;
        v.mi = mi; v.ho = ho; v.dy = dy; v.al = al;
        return v;
    endfunction

    initial begin
        logic r, d, e;
        vec_t t;
        int   nm;

        rst_n = 0; tick = 0; set_valid = 0;
        set_hh = 0; set_mm = 0; set_ss = 0;
        alarm_en = 0; alarm_hh = 0; alarm_mm = 0;

        // rst tk sv  sh    sm    ss  ae ah    am  | rdy dn er | hh mm ss | mi ho dy al
        tbl.push_back(mk(0,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,0,0, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,0,0, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h23,8'h59,8'h58, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,1,0, 8'h23,8'h59,8'h58, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h23,8'h59,8'h59, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h00, 1,1,1,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h00,8'h00,8'h09, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,1,0, 8'h00,8'h00,8'h09, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h12,8'h60,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h10, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,0,1, 8'h00,8'h00,8'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h0A,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,0,1, 8'h00,8'h00,8'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h05,8'h05,8'h05, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,1,0, 8'h05,8'h05,8'h05, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h10,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h05,8'h05,8'h05, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,1,0, 8'h10,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h07,8'h29,8'h59, 1,8'h07,8'h30, 1,0,0, 8'h10,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 1,8'h07,8'h30, 0,1,0, 8'h07,8'h29,8'h59, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 1,8'h07,8'h30, 1,0,0, 8'h07,8'h30,8'h00, 1,0,0,1));
        tbl.push_back(mk(1,0,1, 8'h07,8'h29,8'h59, 0,8'h07,8'h30, 1,0,0, 8'h07,8'h30,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h07,8'h30, 0,1,0, 8'h07,8'h29,8'h59, 0,0,0,0));
        tbl.push_back(mk(1,1,0, 8'h00,8'h00,8'h00, 0,8'h07,8'h30, 1,0,0, 8'h07,8'h30,8'h00, 1,0,0,0));
        tbl.push_back(mk(1,0,1, 8'h01,8'h02,8'h03, 0,8'h00,8'h00, 1,0,0, 8'h07,8'h30,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 0,0,0, 8'h00,8'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,0, 8'h00,8'h00,8'h00, 0,8'h00,8'h00, 1,0,0, 8'h00,8'h00,8'h00, 0,0,0,0));

        foreach (tbl[i]) begin
            t = tbl[i];
            rst_n = t.rst; tick = t.tk; set_valid = t.sv;
            set_hh = t.sh; set_mm = t.sm; set_ss = t.ss;
            alarm_en = t.ae; alarm_hh = t.ah; alarm_mm = t.am;
            cycle(0, r, d, e);
            chk($sformatf("row%0d rdy", i), int'(r), int'(t.rdy));
            chk($sformatf("row%0d done", i), int'(d), int'(t.dn));
            chk($sformatf("row%0d err", i), int'(e), int'(t.er));
            chk($sformatf("row%0d time", i), int'({hh, mm, ss}),
                int'({t.eh, t.em, t.es}));
            chk($sformatf("row%0d strobes", i),
                int'({min_pulse, hour_pulse, day_pulse, alarm}),
                int'({t.mi, t.ho, t.dy, t.al}));
        end

        // set_valid held high: a load completes every second cycle.
        tick = 0; alarm_en = 0;
        for (int i = 0; i < 8; i++) begin
            set_valid = 1;
            set_hh = i2b(i); set_mm = i2b(i * 7); set_ss = i2b(50 + i);
            cycle(1, r, d, e);
        end
        set_valid = 0;
        cycle(1, r, d, e);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            tick = ($urandom_range(0, 2) == 0);
            set_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) begin
                set_hh = i2b($urandom_range(0, 23));
                set_mm = $urandom_range(0, 1) ? 8'h59 : i2b($urandom_range(0, 59));
                set_ss = i2b($urandom_range(55, 59));
            end else begin
                {set_hh, set_mm, set_ss} = 24'($urandom);
            end
            alarm_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) begin
                nm = (m_secs / 60 + 1) % 1440;
                alarm_hh = i2b(nm / 60);
                alarm_mm = i2b(nm % 60);
            end else begin
                alarm_hh = i2b($urandom_range(0, 23));
                alarm_mm = i2b($urandom_range(0, 59));
            end
            cycle(1, r, d, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 SHALL have parameter ALARM_ENABLE, default 1; 1 includes the alarm comparator, 0 ties alarm low.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port tick  input  1  one-cycle 1 Hz pulse from the seconds divider.
REQ-005 SHALL have ports set_valid  input  1 and set_ready  output  1; valid/ready time-load handshake.
REQ-006 SHALL have ports set_hh, set_mm, set_ss  input  8 each  packed BCD load values.
REQ-007 SHALL have ports set_done and set_err  output  1 each  one-cycle load result pulses.
REQ-008 SHALL have ports hh, mm, ss  output  8 each  current packed BCD time, 24 h format.
REQ-009 SHALL have ports min_pulse, hour_pulse, day_pulse  output  1 each  one-cycle rollover strobes.
REQ-010 SHALL have ports alarm_en  input  1; alarm_hh, alarm_mm  input  8 each (BCD); alarm  output  1 (one-cycle pulse).

Function
REQ-011 SHALL advance ss by one on each cycle where tick=1 and no commit occurs; the new value is visible the cycle after tick.
REQ-012 SHALL count ss 00..59 and mm 00..59, carrying into the next field; hh counts 00..23.
REQ-013 SHALL keep every BCD nibble in 0..9; low nibble wraps 9->0 with a carry into the high nibble.
REQ-014 SHALL assert min_pulse in the same cycle ss updates 59->00, hour_pulse when mm also wraps 59->00, and day_pulse at 23:59:59->00:00:00.
REQ-015 SHALL implement a load FSM with states IDLE and CHECK; set_ready=1 only in IDLE.
REQ-016 SHALL on set_valid&&set_ready capture set_hh/mm/ss into a staging register and move IDLE->CHECK.
REQ-017 SHALL in CHECK validate that every nibble is <=9, hh<=0x23, mm<=0x59 and ss<=0x59, then return to IDLE unconditionally.
REQ-018 SHALL on a valid check load the staged value into hh/mm/ss at the end of CHECK and pulse set_done in that cycle.
REQ-019 SHALL on an invalid check leave the time unchanged and pulse set_err in that cycle.
REQ-020 SHALL give commit priority over tick in the CHECK cycle; that tick is dropped and the time equals the staged value.
REQ-021 SHALL apply a tick during CHECK with an invalid load normally.
REQ-022 SHALL never raise rollover strobes on a commit, even when the loaded value is below the current value.
REQ-023 SHALL, when ALARM_ENABLE=1 and alarm_en=1, pulse alarm in the cycle the time becomes alarm_hh:alarm_mm:00 via tick (coincident with min_pulse); a commit never triggers alarm.
REQ-024 SHALL accept a new load in the cycle after set_done/set_err (back-to-back throughput of 2 cycles per load).

Reset
REQ-025 SHALL on rst_n=0 at a clock edge set hh=mm=ss=0x00, FSM=IDLE, staging=0 and all pulse outputs 0.
REQ-026 SHALL hold set_ready=0 while rst_n=0 and set it to 1 the first cycle after release.
REQ-027 SHALL on reset during CHECK abort the load, with no set_done or set_err.
REQ-028 SHALL ignore ticks present in reset cycles.

Structure
REQ-029 SHALL place the FSM state encoding, BCD limits (0x59, 0x23) and the field width constant in shared package rtc_pkg.
REQ-030 SHALL implement each field with one sub-module bcd_mod_counter, with parameterized max BCD value, inputs inc/load/load_val and carry output, instantiated three times.

Verification
REQ-031 SHALL cover wrap: load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00, with min/hour/day_pulse all high on the 2nd tick's update cycle only.
REQ-032 SHALL cover BCD carry: load 00:00:09, then 1 tick -> ss=0x10, with no min_pulse.
REQ-033 SHALL cover invalid load: set 12:60:00 -> set_err one cycle, time unchanged, set_ready high next cycle; also nibble 0x0A -> set_err.
REQ-034 SHALL cover collision: time 05:05:05, valid load 10:00:00 with tick in CHECK -> time 10:00:00, set_done, no strobes.
REQ-035 SHALL cover alarm: alarm_en=1, alarm 07:30, load 07:29:59, 1 tick -> alarm and min_pulse together; with alarm_en=0 -> no alarm.
REQ-036 SHALL cover reset mid-load: assert rst_n=0 in CHECK -> 00:00:00, no result pulse, set_ready=1 one cycle after release.
